// File: rtl/piso_pkg.sv
// Shared types and frame-length helper for the serial transmitter.
// Define PISO_PARITY_EN to append one even-parity bit to every frame.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    localparam int DEFAULT_WIDTH = 8;

`ifdef PISO_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: index of the bit currently on the line, with last/penultimate flags.
// Latency: count updates one clk after clr/en; flags are decoded from the count register.
// Backpressure: none, the counter follows the enable from the FSM.
module piso_bit_counter #(
    parameter int FRAME_LEN = 8,
    parameter int CW        = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic last,
    output logic penult
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    // The top uses penult to register done/load_ready one cycle ahead of the last bit.
    assign last   = (count == CW'(FRAME_LEN - 1));
    assign penult = (count == CW'(FRAME_LEN - 2));

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter, MSB first; PISO_PARITY_EN adds an even-parity bit.
// Latency: first bit on q the cycle after accept; one bit per clk thereafter.
// Backpressure: load_ready only in IDLE and the last-bit cycle; a word taken then streams with no bubble.
module piso_serial_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             q,
    output logic             q_valid,
    output logic             done
);

    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam int CW        = $clog2(WIDTH + 1);

    piso_state_t      state;
    logic [WIDTH-1:0] sr;
    logic             last;
    logic             penult;
    logic             accept;
    logic             in_frame;
`ifdef PISO_PARITY_EN
    logic             par;
`endif

    assign accept   = load_valid & load_ready;
    assign in_frame = (state != IDLE);

    piso_bit_counter #(
        .FRAME_LEN (FRAME_LEN),
        .CW        (CW)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .clr    (last & in_frame),
        .en     (in_frame),
        .last   (last),
        .penult (penult)
    );

    // sr holds the bits still to be sent, left-aligned; q is the bit on the line now.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= '0;
            q          <= 1'b0;
            q_valid    <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
`ifdef PISO_PARITY_EN
            par        <= 1'b0;
`endif
        end else if (accept) begin
            state      <= SHIFT;
            sr         <= {d_in[WIDTH-2:0], 1'b0};
            q          <= d_in[WIDTH-1];
            q_valid    <= 1'b1;
            done       <= 1'b0;
            load_ready <= 1'b0;
`ifdef PISO_PARITY_EN
            par        <= ^d_in;
`endif
        end else if (!in_frame || last) begin
            state      <= IDLE;
            q          <= 1'b0;
            q_valid    <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            done       <= penult;
            load_ready <= penult;
`ifdef PISO_PARITY_EN
            if (penult) begin
                state <= PARITY;
                q     <= par;
            end else begin
                q  <= sr[WIDTH-1];
                sr <= sr << 1;
            end
`else
            q  <= sr[WIDTH-1];
            sr <= sr << 1;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx (WIDTH=8), with and without PISO_PARITY_EN.
module tb_piso_serial_tx;

`ifdef PISO_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] d_in;
    logic       load_valid;
    logic       load_ready;
    logic       q;
    logic       q_valid;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    piso_serial_tx #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .d_in       (d_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .q          (q),
        .q_valid    (q_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_q"}, 32'(q), 32'd0);
        chk({tag, "_qv"}, 32'(q_valid), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rdy"}, 32'(load_ready), 32'd1);
    endtask

    // Present a word and take it on the next edge; d_in is then scrambled.
    task automatic start(input logic [7:0] w);
        d_in       = w;
        load_valid = 1'b1;
        chk("rdy_at_accept", 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0;
        d_in       = 8'h5A ^ w;
    endtask

    // Called in cycle +1 of frame w. chain: accept nxt in the last-bit cycle.
    // hold: present nxt with load_valid from cycle +1, so it waits for load_ready.
    task automatic watch(input logic [7:0] w, input bit chain, input bit hold, input logic [7:0] nxt);
        logic exp_bit;
        for (int i = 1; i <= FL; i++) begin
            exp_bit = (i <= 8) ? w[8-i] : ^w;
            chk("q_bit", 32'(q), 32'(exp_bit));
            chk("q_valid", 32'(q_valid), 32'd1);
            chk("done", 32'(done), 32'(i == FL));
            chk("load_ready", 32'(load_ready), 32'(i == FL));
            if (hold) begin
                d_in       = nxt;
                load_valid = 1'b1;
            end
            if (i == FL && chain) begin
                d_in       = nxt;
                load_valid = 1'b1;
            end
            step();
        end
        if (chain || hold) begin
            load_valid = 1'b0;
            d_in       = 8'h00;
        end else begin
            check_idle("after_frame");
        end
    endtask

    initial begin
        reset      = 1'b1;
        d_in       = 8'hC3;
        load_valid = 1'b1;
        step();
        step();
        check_idle("in_reset");
        reset      = 1'b0;
        load_valid = 1'b0;
        step();
        check_idle("post_reset");

        // A5 (parity 0)
        start(8'hA5);
        watch(8'hA5, 1'b0, 1'b0, 8'h00);

        // 01 (parity 1)
        step();
        start(8'h01);
        watch(8'h01, 1'b0, 1'b0, 8'h00);

        // FF then 00 back-to-back
        start(8'hFF);
        watch(8'hFF, 1'b1, 1'b0, 8'h00);
        watch(8'h00, 1'b0, 1'b0, 8'h00);

        // 3C held during a busy frame, taken only at the last bit
        start(8'h96);
        watch(8'h96, 1'b0, 1'b1, 8'h3C);
        watch(8'h3C, 1'b0, 1'b0, 8'h00);

        // Reset during bit 3 of A5
        start(8'hA5);
        chk("abort_b1", 32'(q), 32'd1);
        step();
        chk("abort_b2", 32'(q), 32'd0);
        step();
        chk("abort_b3", 32'(q), 32'd1);
        chk("abort_b3_qv", 32'(q_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("abort_reset");
        for (int i = 0; i < FL; i++) begin
            step();
            check_idle("abort_quiet");
        end
        start(8'h81);
        watch(8'h81, 1'b0, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
